openhmc_rf_access_master: RTL and testbench
===========================================

Name: openhmc_rf_access_master

Overview:
- Single-outstanding command sequencer that drives the openHMC controller register-file port (rf_address, rf_read_en, rf_write_en, rf_write_data) from a simple valid/ready command channel.
- Returns read data and error status on a valid/ready response channel.
- Sits directly upstream of the controller RF interface, in the clk_hmc domain. It guarantees rf_read_en and rf_write_en are never asserted together, and guards every access with a completion timeout.

Parameters:
- HMC_RF_AWIDTH, 4, RF address width.
- HMC_RF_WWIDTH, 64, RF write data width.
- HMC_RF_RWIDTH, 64, RF read data width.
- TIMEOUT_LOG, 8, width of the timeout counter.
- TIMEOUT_CYCLES, 255, maximum WAIT cycles before timeout. Range 0..2^TIMEOUT_LOG-1. A value of 0 disables the timeout.

Ports:
- clk_hmc  in  1  Block clock.
- res_n_hmc  in  1  Reset, asynchronous, active-low.
- cmd_valid  in  1  Command valid.
- cmd_ready  out  1  Command ready.
- cmd_write  in  1  1 = write, 0 = read.
- cmd_addr  in  HMC_RF_AWIDTH  Command address.
- cmd_wdata  in  HMC_RF_WWIDTH  Command write data.
- rsp_valid  out  1  Response valid.
- rsp_ready  in  1  Response ready.
- rsp_rdata  out  HMC_RF_RWIDTH  Read data. 0 for writes and timeouts.
- rsp_invalid  out  1  RF reported an invalid address.
- rsp_timeout  out  1  No completion arrived within TIMEOUT_CYCLES.
- rf_address  out  HMC_RF_AWIDTH  RF address.
- rf_read_en  out  1  RF read strobe.
- rf_write_en  out  1  RF write strobe.
- rf_write_data  out  HMC_RF_WWIDTH  RF write data.
- rf_read_data  in  HMC_RF_RWIDTH  RF read data.
- rf_access_complete  in  1  RF completion pulse.
- rf_invalid_address  in  1  Invalid-address flag, qualified by rf_access_complete.
- busy  out  1  High in every state other than IDLE.
- spurious_cmpl  out  1  One-cycle pulse: rf_access_complete seen in IDLE or RESP.

Behaviour:
- Reset (asynchronous, immediate): state IDLE; all outputs 0 except cmd_ready = 1; timeout counter 0.
  - A reset mid-access abandons the access.
  - Strobes drop in the same instant and no response is produced.
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - cmd_ready = 1.
  - On cmd_valid && cmd_ready, latch cmd_write, cmd_addr and cmd_wdata, then go to ISSUE.
- ISSUE (exactly 1 cycle):
  - rf_write_en = cmd_write and rf_read_en = !cmd_write. They are never both 1.
  - rf_address and rf_write_data are driven from the latch. rf_write_data is 0 for reads.
  - If rf_access_complete is high in this cycle, capture and go to RESP. Otherwise go to WAIT with the counter cleared to 0.
- WAIT:
  - Both strobes are 0. rf_address and rf_write_data stay stable.
  - The counter increments by 1 each cycle.
  - On rf_access_complete:
    - rsp_rdata = rf_read_data for reads, 0 for writes.
    - rsp_invalid = rf_invalid_address.
    - rsp_timeout = 0.
    - Go to RESP.
  - Otherwise, if TIMEOUT_CYCLES != 0 and the counter == TIMEOUT_CYCLES-1:
    - rsp_timeout = 1, rsp_rdata = 0, rsp_invalid = 0.
    - Go to RESP.
  - If completion and the timeout limit coincide in the same cycle, completion wins.
- RESP:
  - rsp_valid = 1. rsp_* fields are held stable until rsp_ready.
  - rsp_valid never drops without a handshake.
  - On rsp_ready, go to IDLE, and rsp_valid deasserts next cycle.
  - rf_address stays stable until IDLE. rf_address and rf_write_data keep their last value in IDLE.
- cmd_ready is 0 outside IDLE, so only one access is outstanding at a time.
- Best-case spacing:
  - Accept in cycle N, strobe in N+1, complete in N+1, rsp_valid in N+2.
  - With rsp_ready high, the next accept is in N+3.
- Spurious completion:
  - rf_access_complete in IDLE or RESP, including a late completion after a timeout, is ignored.
  - It pulses spurious_cmpl for 1 cycle, registered, and does not alter rsp_* or the state.
- Timeout counter:
  - TIMEOUT_LOG bits, saturating, never wraps.
  - TIMEOUT_CYCLES=0 means WAIT lasts until completion.

Test Plan:
- Read, addr 4'h3, completion 3 cycles after ISSUE with rf_read_data=64'hDEAD_BEEF_0123_4567:
  - rf_read_en high exactly 1 cycle, rf_address=3.
  - rsp_valid with rsp_rdata=64'hDEAD_BEEF_0123_4567, rsp_invalid=0, rsp_timeout=0.
- Write, addr 4'h0, wdata 64'h1, completion in the ISSUE cycle, rsp_ready tied 1:
  - rf_write_en 1 cycle, rsp_valid 1 cycle later with rsp_rdata=0.
  - A second command is accepted 3 cycles after the first.
- Read with no completion, TIMEOUT_CYCLES=4:
  - rsp_timeout=1 after exactly 4 WAIT cycles.
  - A late completion 2 cycles later gives spurious_cmpl one pulse and no second response.
- Completion with rf_invalid_address=1, rsp_ready held 0 for 5 cycles:
  - rsp_valid and rsp_invalid=1 held stable all 5 cycles.
  - cmd_ready stays 0 until the handshake.
- Random back-to-back reads and writes, 1000 commands:
  - Never rf_read_en && rf_write_en.
  - Each command produces exactly one strobe and one response, in order.
- res_n_hmc asserted during WAIT:
  - All outputs go to their reset values immediately, with no response after release.
  - The next command completes normally.

Source files
------------

// File: rtl/openhmc_rf_access_master_if.sv
// Command/response channel between a requester and the RF access master.
// The requester is the master; the RF access master is the slave.
interface openhmc_rf_access_master_if #(
   parameter int HMC_RF_AWIDTH = 4,
   parameter int HMC_RF_WWIDTH = 64,
   parameter int HMC_RF_RWIDTH = 64
);
   logic                     cmd_valid;
   logic                     cmd_ready;
   logic                     cmd_write;
   logic [HMC_RF_AWIDTH-1:0] cmd_addr;
   logic [HMC_RF_WWIDTH-1:0] cmd_wdata;
   logic                     rsp_valid;
   logic                     rsp_ready;
   logic [HMC_RF_RWIDTH-1:0] rsp_rdata;
   logic                     rsp_invalid;
   logic                     rsp_timeout;

   modport master (
      output cmd_valid, cmd_write, cmd_addr, cmd_wdata, rsp_ready,
      input  cmd_ready, rsp_valid, rsp_rdata, rsp_invalid, rsp_timeout
   );

   modport slave (
      input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, rsp_ready,
      output cmd_ready, rsp_valid, rsp_rdata, rsp_invalid, rsp_timeout
   );
endinterface

// File: rtl/openhmc_rf_access_master.sv
// Single-outstanding sequencer for the openHMC register-file port, with
// completion timeout and spurious-completion flagging.
//
// state | meaning
// IDLE  | ready for a command; rf_address/rf_write_data hold last access
// ISSUE | one-cycle read or write strobe
// WAIT  | strobes low, counting cycles until completion or timeout
// RESP  | response presented until rsp_ready
module openhmc_rf_access_master #(
   parameter int HMC_RF_AWIDTH  = 4,
   parameter int HMC_RF_WWIDTH  = 64,
   parameter int HMC_RF_RWIDTH  = 64,
   parameter int TIMEOUT_LOG    = 8,
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic                     clk_hmc,
   input  logic                     res_n_hmc,
   openhmc_rf_access_master_if.slave cmd_rsp,
   output logic [HMC_RF_AWIDTH-1:0] rf_address,
   output logic                     rf_read_en,
   output logic                     rf_write_en,
   output logic [HMC_RF_WWIDTH-1:0] rf_write_data,
   input  logic [HMC_RF_RWIDTH-1:0] rf_read_data,
   input  logic                     rf_access_complete,
   input  logic                     rf_invalid_address,
   output logic                     busy,
   output logic                     spurious_cmpl
);
   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_e;

   localparam logic [TIMEOUT_LOG-1:0] CNT_LAST =
      TIMEOUT_LOG'((TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1);
   localparam logic [TIMEOUT_LOG-1:0] CNT_MAX  = '1;
   localparam bit                     TO_EN    = (TIMEOUT_CYCLES != 0);

   state_e                   state_q, state_d;
   logic                     write_q, write_d;
   logic [HMC_RF_AWIDTH-1:0] addr_q, addr_d;
   logic [HMC_RF_WWIDTH-1:0] wdata_q, wdata_d;
   logic [TIMEOUT_LOG-1:0]   cnt_q, cnt_d;
   logic [HMC_RF_RWIDTH-1:0] rdata_q, rdata_d;
   logic                     invalid_q, invalid_d;
   logic                     timeout_q, timeout_d;
   logic                     spur_q, spur_d;

   always_ff @(posedge clk_hmc or negedge res_n_hmc) begin
      if (!res_n_hmc) begin
         state_q   <= IDLE;
         write_q   <= 1'b0;
         addr_q    <= '0;
         wdata_q   <= '0;
         cnt_q     <= '0;
         rdata_q   <= '0;
         invalid_q <= 1'b0;
         timeout_q <= 1'b0;
         spur_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         write_q   <= write_d;
         addr_q    <= addr_d;
         wdata_q   <= wdata_d;
         cnt_q     <= cnt_d;
         rdata_q   <= rdata_d;
         invalid_q <= invalid_d;
         timeout_q <= timeout_d;
         spur_q    <= spur_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      write_d   = write_q;
      addr_d    = addr_q;
      wdata_d   = wdata_q;
      cnt_d     = cnt_q;
      rdata_d   = rdata_q;
      invalid_d = invalid_q;
      timeout_d = timeout_q;
      spur_d    = rf_access_complete && ((state_q == IDLE) || (state_q == RESP));
      case (state_q)
         IDLE: begin
            if (cmd_rsp.cmd_valid) begin
               write_d = cmd_rsp.cmd_write;
               addr_d  = cmd_rsp.cmd_addr;
               wdata_d = cmd_rsp.cmd_write ? cmd_rsp.cmd_wdata : '0;
               state_d = ISSUE;
            end
         end
         ISSUE: begin
            if (rf_access_complete) begin
               rdata_d   = write_q ? '0 : rf_read_data;
               invalid_d = rf_invalid_address;
               timeout_d = 1'b0;
               state_d   = RESP;
            end else begin
               cnt_d   = '0;
               state_d = WAIT;
            end
         end
         WAIT: begin
            if (cnt_q != CNT_MAX) cnt_d = cnt_q + 1'b1;
            // Completion takes priority over a coincident timeout.
            if (rf_access_complete) begin
               rdata_d   = write_q ? '0 : rf_read_data;
               invalid_d = rf_invalid_address;
               timeout_d = 1'b0;
               state_d   = RESP;
            end else if (TO_EN && (cnt_q == CNT_LAST)) begin
               rdata_d   = '0;
               invalid_d = 1'b0;
               timeout_d = 1'b1;
               state_d   = RESP;
            end
         end
         RESP: begin
            if (cmd_rsp.rsp_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   assign cmd_rsp.cmd_ready   = (state_q == IDLE);
   assign cmd_rsp.rsp_valid   = (state_q == RESP);
   assign cmd_rsp.rsp_rdata   = rdata_q;
   assign cmd_rsp.rsp_invalid = invalid_q;
   assign cmd_rsp.rsp_timeout = timeout_q;
   assign rf_address          = addr_q;
   assign rf_write_data       = wdata_q;
   assign rf_read_en          = (state_q == ISSUE) && !write_q;
   assign rf_write_en         = (state_q == ISSUE) && write_q;
   assign busy                = (state_q != IDLE);
   assign spurious_cmpl       = spur_q;
endmodule

// File: tb/tb_openhmc_rf_access_master.sv
// Scoreboard bench for openhmc_rf_access_master with a behavioural RF model.
module tb_openhmc_rf_access_master;
   localparam int TO_CYC = 4;

   logic        clk_hmc = 1'b0;
   logic        res_n_hmc;
   logic [3:0]  rf_address;
   logic        rf_read_en, rf_write_en;
   logic [63:0] rf_write_data, rf_read_data;
   logic        rf_access_complete, rf_invalid_address;
   logic        busy, spurious_cmpl;

   openhmc_rf_access_master_if #(.HMC_RF_AWIDTH(4), .HMC_RF_WWIDTH(64), .HMC_RF_RWIDTH(64)) bus ();

   openhmc_rf_access_master #(
      .HMC_RF_AWIDTH(4), .HMC_RF_WWIDTH(64), .HMC_RF_RWIDTH(64),
      .TIMEOUT_LOG(8), .TIMEOUT_CYCLES(TO_CYC)
   ) dut (
      .clk_hmc(clk_hmc), .res_n_hmc(res_n_hmc), .cmd_rsp(bus),
      .rf_address(rf_address), .rf_read_en(rf_read_en), .rf_write_en(rf_write_en),
      .rf_write_data(rf_write_data), .rf_read_data(rf_read_data),
      .rf_access_complete(rf_access_complete), .rf_invalid_address(rf_invalid_address),
      .busy(busy), .spurious_cmpl(spurious_cmpl)
   );

   always #5 clk_hmc = ~clk_hmc;

   typedef struct {
      logic        w;
      logic [3:0]  addr;
      logic [63:0] wdata;
      int          delay;
      logic        inv;
      logic [63:0] rdata;
   } cmd_t;

   typedef struct {
      logic [63:0] rdata;
      logic        inv;
      logic        to;
      int          lat;
   } rsp_t;

   cmd_t rfq[$];
   rsp_t expq[$];
   int   n_tests = 0, n_fail = 0;
   int   cyc = 0, strobe_cyc = 0;
   int   ncmd = 0, nstrobe = 0, nrsp = 0, spur_cnt = 0;
   int   hold_cnt = 0;
   bit   rand_ready = 0;

   always @(posedge clk_hmc) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", tag, obs, exp, cyc);
      end
   endtask

   // Behavioural RF: completes each strobe after its scripted delay (255 = never).
   initial begin : rf_model
      cmd_t c;
      rf_access_complete = 1'b0;
      rf_invalid_address = 1'b0;
      rf_read_data       = '0;
      forever begin
         @(negedge clk_hmc);
         rf_access_complete = 1'b0;
         rf_invalid_address = 1'b0;
         rf_read_data       = {$urandom, $urandom};
         if (res_n_hmc && (rf_read_en || rf_write_en)) begin
            nstrobe++;
            strobe_cyc = cyc;
            if (rfq.size() == 0) begin
               chk("strobe_unexpected", 64'(rf_read_en | rf_write_en), 64'h0);
            end else begin
               c = rfq.pop_front();
               chk("strobe_kind", 64'(rf_write_en), 64'(c.w));
               chk("rf_addr", 64'(rf_address), 64'(c.addr));
               chk("rf_wdata", rf_write_data, c.w ? c.wdata : 64'h0);
               if (c.delay != 255) begin
                  if (c.delay > 0) repeat (c.delay) @(negedge clk_hmc);
                  rf_access_complete = 1'b1;
                  rf_invalid_address = c.inv;
                  rf_read_data       = c.rdata;
               end
            end
         end
      end
   end

   // Response monitor: drives rsp_ready, checks order, latency and hold stability.
   initial begin : rsp_mon
      rsp_t        e;
      logic        r, prev_hold, prev_strobe;
      logic [63:0] h_rdata;
      logic        h_inv, h_to;
      bus.rsp_ready = 1'b0;
      prev_hold = 1'b0;
      prev_strobe = 1'b0;
      h_rdata = '0; h_inv = 1'b0; h_to = 1'b0;
      forever begin
         @(negedge clk_hmc);
         if (!res_n_hmc) begin
            bus.rsp_ready = 1'b0;
            prev_hold = 1'b0;
            prev_strobe = 1'b0;
            continue;
         end
         chk("strobe_excl", 64'(rf_read_en && rf_write_en), 64'h0);
         chk("busy", 64'(busy), 64'(!bus.cmd_ready));
         if (rf_read_en || rf_write_en) chk("strobe_1cyc", 64'(prev_strobe), 64'h0);
         prev_strobe = rf_read_en || rf_write_en;
         if (spurious_cmpl) spur_cnt++;
         if (prev_hold) begin
            chk("hold_valid", 64'(bus.rsp_valid), 64'h1);
            chk("hold_rdata", bus.rsp_rdata, h_rdata);
            chk("hold_inv", 64'(bus.rsp_invalid), 64'(h_inv));
            chk("hold_to", 64'(bus.rsp_timeout), 64'(h_to));
         end
         if (bus.rsp_valid) begin
            chk("cmd_ready_in_resp", 64'(bus.cmd_ready), 64'h0);
            if (!prev_hold && expq.size() > 0)
               chk("rsp_latency", 64'(cyc - strobe_cyc), 64'(expq[0].lat));
         end
         if (bus.rsp_valid && hold_cnt > 0) begin
            r = 1'b0;
            hold_cnt--;
         end else if (rand_ready) begin
            r = 1'($urandom_range(0, 1));
         end else begin
            r = 1'b1;
         end
         bus.rsp_ready = r;
         if (bus.rsp_valid && r) begin
            if (expq.size() == 0) begin
               chk("rsp_unexpected", 64'(bus.rsp_valid), 64'h0);
            end else begin
               e = expq.pop_front();
               chk("rsp_rdata", bus.rsp_rdata, e.rdata);
               chk("rsp_invalid", 64'(bus.rsp_invalid), 64'(e.inv));
               chk("rsp_timeout", 64'(bus.rsp_timeout), 64'(e.to));
               nrsp++;
            end
         end
         prev_hold = bus.rsp_valid && !r;
         h_rdata = bus.rsp_rdata;
         h_inv   = bus.rsp_invalid;
         h_to    = bus.rsp_timeout;
      end
   end

   task automatic send(input logic w, input logic [3:0] a, input logic [63:0] wd, input int d,
                       input logic inv, input logic [63:0] rd, output int acc_cyc);
      cmd_t c;
      rsp_t r;
      int   n;
      c.w = w; c.addr = a; c.wdata = wd; c.delay = d; c.inv = inv; c.rdata = rd;
      r.to    = (d > TO_CYC);
      r.rdata = (r.to || w) ? 64'h0 : rd;
      r.inv   = r.to ? 1'b0 : inv;
      r.lat   = r.to ? TO_CYC + 1 : d + 1;
      bus.cmd_valid = 1'b1;
      bus.cmd_write = w;
      bus.cmd_addr  = a;
      bus.cmd_wdata = wd;
      n = 0;
      while (!bus.cmd_ready && n < 100) begin
         @(negedge clk_hmc);
         n++;
      end
      acc_cyc = -1;
      if (!bus.cmd_ready) begin
         chk("accept_wait", 64'(bus.cmd_ready), 64'h1);
      end else begin
         rfq.push_back(c);
         expq.push_back(r);
         ncmd++;
         acc_cyc = cyc;
      end
      @(negedge clk_hmc);
      bus.cmd_valid = 1'b0;
   endtask

   task automatic drain();
      int n = 0;
      while (expq.size() > 0 && n < 200) begin
         @(negedge clk_hmc);
         n++;
      end
      @(negedge clk_hmc);
      chk("drain", 64'(expq.size()), 64'h0);
   endtask

   task automatic chk_reset_outputs(input string tag);
      chk({tag, "_cmd_ready"}, 64'(bus.cmd_ready), 64'h1);
      chk({tag, "_busy"}, 64'(busy), 64'h0);
      chk({tag, "_rsp_valid"}, 64'(bus.rsp_valid), 64'h0);
      chk({tag, "_strobes"}, 64'({rf_read_en, rf_write_en}), 64'h0);
      chk({tag, "_rf_addr"}, 64'(rf_address), 64'h0);
      chk({tag, "_rf_wdata"}, rf_write_data, 64'h0);
      chk({tag, "_rsp_fields"}, 64'({bus.rsp_invalid, bus.rsp_timeout}), 64'h0);
      chk({tag, "_rsp_rdata"}, bus.rsp_rdata, 64'h0);
      chk({tag, "_spurious"}, 64'(spurious_cmpl), 64'h0);
   endtask

   initial begin : main
      int a0, a1, sp0, r0, d;
      res_n_hmc     = 1'b0;
      bus.cmd_valid = 1'b0;
      bus.cmd_write = 1'b0;
      bus.cmd_addr  = '0;
      bus.cmd_wdata = '0;
      repeat (3) @(negedge clk_hmc);
      chk_reset_outputs("por");
      res_n_hmc = 1'b1;
      @(negedge clk_hmc);

      send(1'b0, 4'h3, 64'h0, 3, 1'b0, 64'hDEAD_BEEF_0123_4567, a0);
      drain();

      send(1'b1, 4'h0, 64'h1, 0, 1'b0, 64'h0, a0);
      send(1'b1, 4'h1, 64'h2, 0, 1'b0, 64'h0, a1);
      chk("b2b_spacing", 64'(a1 - a0), 64'd3);
      drain();

      send(1'b0, 4'h7, 64'h0, TO_CYC, 1'b0, 64'h0123_4567_89AB_CDEF, a0);
      drain();

      sp0 = spur_cnt;
      r0  = nrsp;
      send(1'b0, 4'h2, 64'h0, TO_CYC + 2, 1'b0, 64'hFFFF_0000_FFFF_0000, a0);
      repeat (12) @(negedge clk_hmc);
      chk("late_spurious", 64'(spur_cnt - sp0), 64'd1);
      chk("late_single_rsp", 64'(nrsp - r0), 64'd1);

      hold_cnt = 5;
      send(1'b0, 4'h5, 64'h0, 2, 1'b1, 64'hCAFE_F00D_1234_5678, a0);
      drain();
      chk("hold_consumed", 64'(hold_cnt), 64'h0);

      rand_ready = 1'b1;
      for (int i = 0; i < 1000; i++) begin
         d = ($urandom_range(0, 9) == 0) ? 255 : int'($urandom_range(0, TO_CYC));
         send(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), {$urandom, $urandom}, d,
              1'($urandom_range(0, 7) == 0), {$urandom, $urandom}, a0);
         if ($urandom_range(0, 3) == 0) @(negedge clk_hmc);
      end
      drain();
      rand_ready = 1'b0;

      send(1'b1, 4'hA, 64'h55, 255, 1'b0, 64'h0, a0);
      @(negedge clk_hmc);
      #2 res_n_hmc = 1'b0;
      #1 chk_reset_outputs("rst_wait");
      expq.delete();
      rfq.delete();
      ncmd--;
      repeat (3) @(negedge clk_hmc);
      res_n_hmc = 1'b1;
      repeat (10) @(negedge clk_hmc);
      chk("no_rsp_after_rst", 64'(bus.rsp_valid), 64'h0);
      send(1'b0, 4'h9, 64'h0, 1, 1'b0, 64'h1111_2222_3333_4444, a0);
      drain();

      chk("strobe_count", 64'(nstrobe), 64'(ncmd + 1));
      chk("rsp_count", 64'(nrsp), 64'(ncmd));
      chk("spurious_total", 64'(spur_cnt), 64'd1);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
